// File: rtl/iic_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, FSM states and bit-slot phases.
package iic_pkg;

    localparam logic [1:0] IIC_CMD_START = 2'b00;
    localparam logic [1:0] IIC_CMD_STOP  = 2'b01;
    localparam logic [1:0] IIC_CMD_WRITE = 2'b10;
    localparam logic [1:0] IIC_CMD_READ  = 2'b11;

    // Wide enough for the largest quarter-period count (1023).
    localparam int unsigned IIC_DIV_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStop,
        StWbit,
        StWack,
        StRbit,
        StRack
    } iic_state_e;

    typedef enum logic [1:0] {
        Ph0,
        Ph1,
        Ph2,
        Ph3
    } iic_phase_e;

endpackage

// File: rtl/iic_phase_gen.sv
// Quarter-period divider and 2-bit phase counter for one I2C bit slot.
// With IIC_CLK_STRETCH_EN defined, P1 is extended until the synchronised SCL reads high.
module iic_phase_gen
    import iic_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef IIC_CLK_STRETCH_EN
    input  logic       scl_in,
`endif
    output logic [1:0] phase,
    output logic       phase_end
);

    localparam logic [IIC_DIV_W-1:0] CntLast = IIC_DIV_W'(CLK_DIV - 1);

    logic [IIC_DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]           phase_q, phase_d;
    logic                 cnt_done;
    logic                 hold;

`ifdef IIC_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
        end
    end

    // A slave holding SCL low freezes the count at the end of P1.
    assign hold = (phase_q == Ph1) && !scl_s2_q;
`else
    assign hold = 1'b0;
`endif

    assign cnt_done  = (cnt_q == CntLast);
    assign phase_end = run && cnt_done && !hold;
    assign phase     = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = Ph0;
        end else if (phase_end) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (!cnt_done) begin
            cnt_d = cnt_q + IIC_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= Ph0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/iic_byte_master.sv
// Byte-level I2C master: START/STOP/WRITE/READ commands to open-drain SDA/SCL (O/I/T) drive.
// Optional SCL clock stretching is enabled by defining IIC_CLK_STRETCH_EN.
module iic_byte_master
    import iic_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CMD_VALID_I,
    output logic       CMD_READY_O,
    input  logic [1:0] CMD_I,
    input  logic [7:0] DATA_I,
    input  logic       ACK_I,
    output logic       RSP_VALID_O,
    output logic [7:0] RSP_DATA_O,
    output logic       RSP_NACK_O,
    output logic       BUSY_O,
    output logic       SDA_O,
    input  logic       SDA_I,
    output logic       SDA_T,
    output logic       SCL_O,
    input  logic       SCL_I,
    output logic       SCL_T
);

    iic_state_e state_q, state_d;
    logic [1:0] phase_raw;
    iic_phase_e phase;
    logic       phase_end;
    logic       run;
    logic       accept;
    logic       done;
    logic       slot_end;
    logic       sample;

    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       ack_q;
    logic       nack_q;
    logic       sda_s1_q, sda_s2_q;
    logic       sda_hold_q, scl_hold_q;
    logic       sda_want, scl_want;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_nack_q;
    logic       busy_q;

    assign run      = (state_q != StIdle);
    assign accept   = CMD_VALID_I && (state_q == StIdle);
    assign phase    = iic_phase_e'(phase_raw);
    assign slot_end = phase_end && (phase == Ph3);
    assign sample   = phase_end && (phase == Ph2);

    iic_phase_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_gen (
        .clk      (CLK_I),
        .rst      (RST_I),
        .run      (run),
`ifdef IIC_CLK_STRETCH_EN
        .scl_in   (SCL_I),
`endif
        .phase    (phase_raw),
        .phase_end(phase_end)
    );

`ifndef IIC_CLK_STRETCH_EN
    logic unused_scl;
    assign unused_scl = SCL_I;
`endif

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (CMD_I)
                        IIC_CMD_START: state_d = StStart;
                        IIC_CMD_STOP:  state_d = StStop;
                        IIC_CMD_WRITE: state_d = StWbit;
                        default:       state_d = StRbit;
                    endcase
                end
            end
            StWbit: if (slot_end && bit_cnt_q == 3'd7) state_d = StWack;
            StRbit: if (slot_end && bit_cnt_q == 3'd7) state_d = StRack;
            StStart, StStop, StWack, StRack: begin
                if (slot_end) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line levels per state/phase; idle keeps whatever the last command left on the bus.
    always_comb begin
        sda_want = sda_hold_q;
        scl_want = scl_hold_q;
        unique case (state_q)
            StStart: begin
                unique case (phase)
                    Ph0: sda_want = 1'b1;
                    Ph1: begin sda_want = 1'b1; scl_want = 1'b1; end
                    Ph2: begin sda_want = 1'b0; scl_want = 1'b1; end
                    Ph3: begin sda_want = 1'b0; scl_want = 1'b0; end
                endcase
            end
            StStop: begin
                unique case (phase)
                    Ph0:      sda_want = 1'b0;
                    Ph1, Ph2: begin sda_want = 1'b0; scl_want = 1'b1; end
                    Ph3:      begin sda_want = 1'b1; scl_want = 1'b1; end
                endcase
            end
            StWbit, StWack, StRbit, StRack: begin
                scl_want = (phase == Ph1) || (phase == Ph2);
                if (state_q == StWbit)      sda_want = shift_q[7];
                else if (state_q == StRack) sda_want = !ack_q;
                else                        sda_want = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_hold_q  <= 1'b1;
            scl_hold_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_nack_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sda_s1_q    <= SDA_I;
            sda_s2_q    <= sda_s1_q;
            sda_hold_q  <= sda_want;
            scl_hold_q  <= scl_want;
            rsp_valid_q <= done;

            if (accept) begin
                shift_q   <= DATA_I;
                ack_q     <= ACK_I;
                bit_cnt_q <= '0;
                nack_q    <= 1'b0;
                if (CMD_I == IIC_CMD_START) busy_q <= 1'b1;
            end

            // The write byte and the read byte share one shift register.
            if (slot_end && state_q == StWbit) shift_q <= {shift_q[6:0], 1'b0};
            if (sample && state_q == StRbit)   shift_q <= {shift_q[6:0], sda_s2_q};
            if (sample && state_q == StWack)   nack_q <= sda_s2_q;
            if (slot_end && (state_q == StWbit || state_q == StRbit)) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (done) begin
                rsp_nack_q <= (state_q == StWack) ? nack_q : 1'b0;
                if (state_q == StRack) rsp_data_q <= shift_q;
                if (state_q == StStop) busy_q <= 1'b0;
            end
        end
    end

    assign CMD_READY_O = (state_q == StIdle);
    assign RSP_VALID_O = rsp_valid_q;
    assign RSP_DATA_O  = rsp_data_q;
    assign RSP_NACK_O  = rsp_nack_q;
    assign BUSY_O      = busy_q;
    assign SDA_O       = 1'b0;
    assign SCL_O       = 1'b0;
    assign SDA_T       = sda_want;
    assign SCL_T       = scl_want;

endmodule
